cash_reg_feeder: RTL and testbench
==================================

// Module: cash_reg_feeder
// PURPOSE
//   Upstream stage of the cash register. It buffers item prices from a scanner
//   through a valid/ready FIFO and sequences the register's A/X/T/C controls:
//   ITEM_CYC cycles of A per item, then TOT_CYC cycles of T, then a 1-cycle C.
//   A shadow W-bit running sum with a sticky overflow flag lets the bench
//   cross-check the register's Total output.
// PARAMETERS
//   W        4  price/total width; equals the register's W
//   DEPTH    4  FIFO entries; must be a power of 2 and >= 2
//   ITEM_CYC 3  cycles that A stays high and X stays stable per item (LoadX/AddX/MoreX)
//   TOT_CYC  2  cycles that T stays high (LoadT/DisplayT)
//   CW       8  ItemCount width
// PORTS
//   Clock     in  1   rising-edge clock
//   Resetn    in  1   synchronous, active-low reset
//   InValid   in  1   scanner offers InData
//   InData    in  W   item price
//   InReady   out 1   FIFO not full; low while Resetn=0
//   EndSale   in  1   1-cycle pulse: request total display
//   ClearReq  in  1   1-cycle pulse: request register clear
//   A         out 1   register "add next X"
//   X         out W   price presented to the register (registered)
//   T         out 1   register "display total"
//   C         out 1   register "clear total"
//   Sum       out W   shadow running total, mod 2^W
//   Ovf       out 1   sticky flag: Sum has wrapped
//   ItemCount out CW  items dispatched since clear; saturates at 2^CW-1
//   Busy      out 1   state != IDLE, or FIFO not empty
// BEHAVIOUR
//   Reset (Resetn=0 at an edge):
//   - A=T=C=0, X=0, Sum=0, Ovf=0, ItemCount=0.
//   - FIFO flushed; pending EndSale/ClearReq flags cleared; state=IDLE.
//   - Reset mid-sequence aborts it: outputs drop at that edge.
//   FIFO:
//   - Push on an edge where InValid & InReady.
//   - Pop only in the dispatch cases below; pop reads registered (pre-edge) contents.
//   - A word pushed at edge k can be popped at edge k+1 at the earliest.
//     A is then high from the cycle after edge k+1.
//   - Full: InReady=0, so no push occurs.
//   - Push and pop on the same edge: count unchanged; pointers wrap mod DEPTH.
//   - EndSale and ClearReq are latched into pending flags. A repeat while a flag
//     is already pending is absorbed.
//   FSM states: IDLE, ITEM, TOTAL, SHOW, CLEAR. Priority in IDLE:
//     ClearReq pending > FIFO nonempty > EndSale pending.
//   - IDLE: A=T=C=0.
//       Clear pending -> CLEAR.
//       Else FIFO nonempty -> pop into X, go ITEM, start cycle counter.
//       Else EndSale pending -> TOTAL, clearing the EndSale flag.
//   - ITEM: A=1, X held for ITEM_CYC cycles. On the last cycle:
//       FIFO nonempty and no clear pending -> pop next item and stay in ITEM.
//         A stays high continuously across back-to-back items.
//       Otherwise -> IDLE.
//   - TOTAL: T=1 for TOT_CYC cycles -> SHOW.
//   - SHOW: A=T=0. Items may be pushed but are not dispatched.
//       Clear pending -> CLEAR.
//   - CLEAR: C=1 for exactly 1 cycle. Sum, Ovf and ItemCount zero at the exit
//       edge; clear flag cleared -> IDLE.
//   Arithmetic: on each pop, Sum <= Sum + item (W-bit, carry dropped).
//     Ovf <= Ovf | carry.
//     ItemCount <= ItemCount + 1, saturating.
//   Never high in the same cycle: any two of A, T, C.
//   EndSale with items still queued: all queued items are dispatched first.
// TESTING
//   1 Push 1,2,3 on consecutive cycles from IDLE -> A high 9 consecutive
//     cycles; X=1,2,3 for 3 cycles each; Sum=6, ItemCount=3.
//   2 After test 1, EndSale -> T=1 for exactly 2 cycles, then SHOW with
//     A=T=0; ClearReq -> C=1 for 1 cycle; Sum=0, ItemCount=0.
//   3 Push 9 then 8 (W=4) -> Sum=1, Ovf=1. Ovf stays 1 until a CLEAR.
//   4 In SHOW, push 5 words -> InReady=0 after the 4th; the 5th is held off.
//     ClearReq -> C pulse, then 4 items dispatched in FIFO order.
//   5 EndSale pulsed while 2 items are queued -> T rises only after the
//     last item's 3rd A cycle.
//   6 Resetn=0 during the 2nd ITEM cycle -> A=0, X=0, Sum=0 and InReady=0 at
//     that edge; FIFO empty after reset is released.

Source files
------------

// File: rtl/cash_reg_feeder.sv
// cash_reg_feeder
//   Upstream stage of the cash register. Scanner prices are buffered in a
//   valid/ready FIFO and fed to the register one at a time while the A/T/C
//   controls are sequenced: ITEM_CYC cycles of A per item, TOT_CYC cycles of
//   T for a total display, and a single-cycle C to clear. A shadow running
//   sum with a sticky overflow flag mirrors what the register should total.
//
// Ports
//   Clock     in   rising-edge clock
//   Resetn    in   synchronous active-low reset
//   InValid   in   scanner offers InData
//   InData    in   item price (W bits)
//   InReady   out  FIFO not full; forced low while Resetn=0
//   EndSale   in   pulse: request total display (latched)
//   ClearReq  in   pulse: request register clear (latched)
//   A         out  register "add next X"
//   X         out  price presented to the register (registered)
//   T         out  register "display total"
//   C         out  register "clear total"
//   Sum       out  shadow running total, mod 2^W
//   Ovf       out  sticky: Sum has wrapped since last clear
//   ItemCount out  items dispatched since clear, saturating
//   Busy      out  sequencer not idle, or FIFO holds items
module cash_reg_feeder #(
  parameter int unsigned W        = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ITEM_CYC = 3,
  parameter int unsigned TOT_CYC  = 2,
  parameter int unsigned CW       = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          InValid,
  input  logic [W-1:0]  InData,
  output logic          InReady,
  input  logic          EndSale,
  input  logic          ClearReq,
  output logic          A,
  output logic [W-1:0]  X,
  output logic          T,
  output logic          C,
  output logic [W-1:0]  Sum,
  output logic          Ovf,
  output logic [CW-1:0] ItemCount,
  output logic          Busy
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAXC = (ITEM_CYC > TOT_CYC) ? ITEM_CYC : TOT_CYC;
  localparam int unsigned KW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ITEM,
    TOTAL,
    SHOW,
    CLEAR
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic           end_pend, clr_pend;
  logic [KW-1:0]  cyc;
  logic           full, empty, push, pop;
  logic           cyc_rst, end_take, clr_done;
  logic [W:0]     add;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign InReady = Resetn & ~full;
  assign push    = InValid & InReady;
  assign Busy    = (state != IDLE) | ~empty;

  // Sum plus the word at the head of the FIFO; the carry feeds Ovf.
  assign add = {1'b0, Sum} + {1'b0, mem[rd_ptr]};

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    cyc_rst  = 1'b0;
    end_take = 1'b0;
    clr_done = 1'b0;
    A        = 1'b0;
    T        = 1'b0;
    C        = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          state_nx = CLEAR;
        end else if (!empty) begin
          pop      = 1'b1;
          cyc_rst  = 1'b1;
          state_nx = ITEM;
        end else if (end_pend) begin
          end_take = 1'b1;
          cyc_rst  = 1'b1;
          state_nx = TOTAL;
        end
      end
      ITEM: begin
        A = 1'b1;
        if (cyc == KW'(ITEM_CYC - 1)) begin
          // Chain straight into the next item so A never drops between them.
          if (!empty && !clr_pend) begin
            pop     = 1'b1;
            cyc_rst = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      TOTAL: begin
        T = 1'b1;
        if (cyc == KW'(TOT_CYC - 1)) state_nx = SHOW;
      end
      SHOW: begin
        if (clr_pend) state_nx = CLEAR;
      end
      CLEAR: begin
        C        = 1'b1;
        clr_done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage is not reset; a reset flushes the FIFO through its pointers.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= InData;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      end_pend  <= 1'b0;
      clr_pend  <= 1'b0;
      cyc       <= '0;
      X         <= '0;
      Sum       <= '0;
      Ovf       <= 1'b0;
      ItemCount <= '0;
    end else begin
      state    <= state_nx;
      end_pend <= (end_pend & ~end_take) | EndSale;
      clr_pend <= (clr_pend & ~clr_done) | ClearReq;

      if (cyc_rst)                            cyc <= '0;
      else if (state == ITEM || state == TOTAL) cyc <= cyc + 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        X      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        Sum    <= add[W-1:0];
        Ovf    <= Ovf | add[W];
        if (ItemCount != '1) ItemCount <= ItemCount + 1'b1;
      end

      if (clr_done) begin
        Sum       <= '0;
        Ovf       <= 1'b0;
        ItemCount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cash_reg_feeder.sv
// Testbench for cash_reg_feeder: directed scenarios followed by randomized
// traffic, checked against a transaction-level scoreboard of queued prices,
// running total, overflow and item count.
module tb_cash_reg_feeder;

  localparam int W        = 4;
  localparam int DEPTH    = 4;
  localparam int ITEM_CYC = 3;
  localparam int TOT_CYC  = 2;
  localparam int CW       = 8;

  logic          Clock = 1'b0;
  logic          Resetn, InValid, EndSale, ClearReq;
  logic [W-1:0]  InData;
  logic          InReady, A, T, C, Ovf, Busy;
  logic [W-1:0]  X, Sum;
  logic [CW-1:0] ItemCount;

  always #5 Clock = ~Clock;

  cash_reg_feeder #(
    .W(W), .DEPTH(DEPTH), .ITEM_CYC(ITEM_CYC), .TOT_CYC(TOT_CYC), .CW(CW)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .InValid(InValid), .InData(InData),
    .InReady(InReady), .EndSale(EndSale), .ClearReq(ClearReq),
    .A(A), .X(X), .T(T), .C(C), .Sum(Sum), .Ovf(Ovf),
    .ItemCount(ItemCount), .Busy(Busy)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard state
  int mq[$];
  int tot = 0;
  int ovf_m = 0;
  int cnt_m = 0;
  int arun = 0, trun = 0, crun = 0;
  int last_arun = 0, last_trun = 0, last_crun = 0;
  int ndisp = 0;
  int cyc = 0;
  int last_a_cyc = 0, t_rise_cyc = 0;
  bit prevc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs already driven, sample 1 time unit after the edge.
  task automatic step();
    bit rst_e, acc;
    int pre, item;
    rst_e = !Resetn;
    acc   = Resetn && InValid && (mq.size() < DEPTH);
    pre   = mq.size();
    @(posedge Clock);
    #1;
    cyc++;
    if (rst_e) begin
      mq.delete();
      tot = 0; ovf_m = 0; cnt_m = 0;
      arun = 0; trun = 0; crun = 0; prevc = 1'b0;
      chk("rst_A", A, 0);
      chk("rst_T", T, 0);
      chk("rst_C", C, 0);
      chk("rst_X", X, 0);
      chk("rst_sum", Sum, 0);
      chk("rst_ovf", Ovf, 0);
      chk("rst_count", ItemCount, 0);
      chk("rst_ready", InReady, 0);
      return;
    end
    if (acc) mq.push_back(int'(InData));
    if (prevc) begin
      tot = 0; ovf_m = 0; cnt_m = 0;
    end
    // A new item begins whenever A is high at an item boundary.
    if (A && (arun % ITEM_CYC == 0)) begin
      chk("pop_nonempty", pre > 0, 1);
      if (pre > 0) begin
        item = mq.pop_front();
        chk("x_order", X, item);
        tot = tot + item;
        if (tot >= (1 << W)) begin
          tot   = tot - (1 << W);
          ovf_m = 1;
        end
        if (cnt_m < (1 << CW) - 1) cnt_m++;
        ndisp++;
      end
    end
    if (A) arun++;
    else begin
      if (arun > 0) begin
        last_arun  = arun;
        last_a_cyc = cyc - 1;
        chk("a_run_whole_items", arun % ITEM_CYC, 0);
      end
      arun = 0;
    end
    if (T) begin
      if (trun == 0) t_rise_cyc = cyc;
      trun++;
    end else begin
      if (trun > 0) begin
        last_trun = trun;
        chk("t_run_len", trun, TOT_CYC);
      end
      trun = 0;
    end
    if (C) crun++;
    else begin
      if (crun > 0) begin
        last_crun = crun;
        chk("c_run_len", crun, 1);
      end
      crun = 0;
    end
    prevc = C;
    chk("atc_exclusive", (int'(A) + int'(T) + int'(C)) <= 1, 1);
    chk("ready", InReady, (Resetn && mq.size() < DEPTH));
    chk("sum", Sum, tot);
    chk("ovf", Ovf, ovf_m);
    chk("item_count", ItemCount, cnt_m);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return A;
      1:       return T;
      2:       return C;
      default: return Busy;
    endcase
  endfunction

  // Step until the selected output reaches val, bounded; a timeout fails.
  task automatic wait_sig(input int sel, input logic val, input string tag, input int limit);
    int n;
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      step();
      n++;
    end
    chk(tag, sig(sel), val);
  endtask

  task automatic pulse_clear();
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
  endtask

  task automatic pulse_end();
    EndSale = 1'b1;
    step();
    EndSale = 1'b0;
  endtask

  initial begin
    int base, n;
    Resetn = 1'b0; InValid = 1'b0; InData = '0; EndSale = 1'b0; ClearReq = 1'b0;
    step();
    step();
    Resetn = 1'b1;
    step();
    chk("idle_busy", Busy, 0);

    // Three back-to-back items
    InValid = 1'b1; InData = 4'd1; step();
    InData = 4'd2; step();
    InData = 4'd3; step();
    InValid = 1'b0;
    wait_sig(0, 1'b0, "t1_a_done", 40);
    chk("t1_a_run", last_arun, 9);
    chk("t1_sum", Sum, 6);
    chk("t1_count", ItemCount, 3);

    // Total display then clear
    pulse_end();
    wait_sig(1, 1'b1, "t2_t_rise", 10);
    wait_sig(1, 1'b0, "t2_t_fall", 10);
    chk("t2_t_len", last_trun, 2);
    chk("t2_show_A", A, 0);
    step();
    step();
    chk("t2_show_T", T, 0);
    chk("t2_show_busy", Busy, 1);
    pulse_clear();
    wait_sig(2, 1'b1, "t2_c_rise", 10);
    wait_sig(2, 1'b0, "t2_c_fall", 10);
    chk("t2_c_len", last_crun, 1);
    chk("t2_sum", Sum, 0);
    chk("t2_count", ItemCount, 0);

    // Wraparound sets sticky overflow
    InValid = 1'b1; InData = 4'd9; step();
    InData = 4'd8; step();
    InValid = 1'b0;
    wait_sig(0, 1'b0, "t3_a_done", 40);
    chk("t3_sum", Sum, 1);
    chk("t3_ovf", Ovf, 1);
    InValid = 1'b1; InData = 4'd1; step();
    InValid = 1'b0;
    wait_sig(0, 1'b1, "t3_a2_rise", 10);
    wait_sig(0, 1'b0, "t3_a2_done", 20);
    chk("t3_ovf_sticky", Ovf, 1);
    chk("t3_sum2", Sum, 2);
    pulse_clear();
    wait_sig(2, 1'b1, "t3_c_rise", 10);
    wait_sig(2, 1'b0, "t3_c_fall", 10);
    chk("t3_ovf_cleared", Ovf, 0);

    // Fill the FIFO while in SHOW
    pulse_end();
    wait_sig(1, 1'b1, "t4_t_rise", 10);
    wait_sig(1, 1'b0, "t4_t_fall", 10);
    InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      InData = 4'(10 + i);
      step();
    end
    chk("t4_full_ready", InReady, 0);
    InData = 4'd14;
    step(); step(); step();
    chk("t4_held_ready", InReady, 0);
    chk("t4_no_dispatch", A, 0);
    InValid = 1'b0;
    base = ndisp;
    pulse_clear();
    wait_sig(2, 1'b1, "t4_c_rise", 10);
    wait_sig(2, 1'b0, "t4_c_fall", 10);
    wait_sig(0, 1'b1, "t4_a_rise", 10);
    wait_sig(0, 1'b0, "t4_a_done", 40);
    chk("t4_dispatched", ndisp - base, 4);
    chk("t4_last_x", X, 13);
    chk("t4_busy", Busy, 0);

    // EndSale while items are queued
    InValid = 1'b1; InData = 4'd4; step();
    InData = 4'd5; step();
    InData = 4'd6; EndSale = 1'b1; step();
    InValid = 1'b0; EndSale = 1'b0;
    wait_sig(1, 1'b1, "t5_t_rise", 40);
    chk("t5_a_run", last_arun, 9);
    chk("t5_gap", t_rise_cyc - last_a_cyc, 2);
    wait_sig(1, 1'b0, "t5_t_fall", 10);
    pulse_clear();
    wait_sig(2, 1'b1, "t5_c_rise", 10);
    wait_sig(2, 1'b0, "t5_c_fall", 10);

    // Reset during the second ITEM cycle
    InValid = 1'b1; InData = 4'd7; step();
    InData = 4'd3; step();
    chk("t6_a_first", A, 1);
    InData = 4'd2; step();
    InValid = 1'b0;
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    step();
    chk("t6_busy", Busy, 0);
    chk("t6_ready", InReady, 1);
    step(); step(); step();
    chk("t6_no_item", A, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      InValid  = ($urandom_range(0, 1) == 1);
      InData   = 4'($urandom);
      EndSale  = ($urandom_range(0, 19) == 0);
      ClearReq = ($urandom_range(0, 24) == 0);
      Resetn   = (i != 150);
      step();
    end
    InValid = 1'b0; EndSale = 1'b0; ClearReq = 1'b0; Resetn = 1'b1;

    // Drain
    n = 0;
    while (n < 400 && (Busy || mq.size() > 0)) begin
      ClearReq = (n % 16 == 0);
      step();
      n++;
    end
    ClearReq = 1'b0;
    chk("drain_queue", mq.size(), 0);
    chk("drain_busy", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
